// File: rtl/prbs8_pkg.sv
// prbs8_pkg: shared PRBS8 polynomial helpers, checker state enum and error-count width.
package prbs8_pkg;
    localparam int ERR_W = 16;
    // Taps 8,6,5,4 map to word bits 7,5,4,3.
    localparam logic [7:0] TAP_MASK = 8'b1011_1000;
    typedef enum logic {HUNT, LOCKED} chk_state_t;
    function automatic logic [7:0] prbs8_next(input logic [7:0] w);
        return {w[6:0], ^(w & TAP_MASK)};
    endfunction
    function automatic logic [3:0] popcount8(input logic [7:0] w);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + 4'(w[i]);
        return c;
    endfunction
endpackage

// File: rtl/prbs8_checker_if.sv
// prbs8_checker_if: received word stream, error clear and checker status outputs.
interface prbs8_checker_if;
    import prbs8_pkg::*;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             err_clr;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             lock_lost;
    modport master (output in_valid, in_data, err_clr, input locked, err_pulse, err_count, lock_lost);
    modport slave  (input in_valid, in_data, err_clr, output locked, err_pulse, err_count, lock_lost);
endinterface

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter: saturating accumulator; clr has priority over the add amount.
module prbs_sat_counter
    import prbs8_pkg::*;
#(
    parameter int W = ERR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [3:0]   amt,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;
    logic [W:0]   sum;
    always_comb begin
        sum     = {1'b0, count_q} + (W+1)'(amt);
        count_d = clr ? '0 : (sum[W] ? '1 : sum[W-1:0]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/prbs8_checker.sv
// prbs8_checker: PRBS8 lock/flywheel checker with error counting and sticky loss flag.
// Define PRBS_CHK_BITERR_EN to count errored bits instead of errored words.
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSE_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    prbs8_checker_if.slave    bus
);
    chk_state_t state_q, state_d;
    logic [7:0] prev_q, prev_d, expected_q, expected_d;
    logic [3:0] match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d;
    logic       err_pulse_q, err_pulse_d, lock_lost_q, lock_lost_d;
    logic       hunt_hit, lock_hit, lost_set;
    logic [3:0] match_inc, miss_inc, miss_amt, err_amt;
`ifdef PRBS_CHK_BITERR_EN
    assign miss_amt = popcount8(bus.in_data ^ expected_q);
`else
    assign miss_amt = 4'd1;
`endif
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        err_amt     = '0;
        lost_set    = 1'b0;
        // Zero word is excluded so a stuck-low line can never lock.
        hunt_hit    = (bus.in_data == prbs8_next(prev_q)) && (bus.in_data != 8'h00);
        lock_hit    = bus.in_data == expected_q;
        match_inc   = match_cnt_q + 4'd1;
        miss_inc    = miss_cnt_q + 4'd1;
        if (bus.in_valid && state_q == HUNT) begin
            prev_d      = bus.in_data;
            match_cnt_d = hunt_hit ? match_inc : '0;
            if (hunt_hit && match_inc == 4'(LOCK_CNT)) begin
                state_d     = LOCKED;
                expected_d  = prbs8_next(bus.in_data);
                match_cnt_d = '0;
                miss_cnt_d  = '0;
            end
        end else if (bus.in_valid) begin
            // Flywheel: the predictor free-runs and is never reseeded from data.
            expected_d  = prbs8_next(expected_q);
            err_pulse_d = !lock_hit;
            err_amt     = lock_hit ? 4'd0 : miss_amt;
            miss_cnt_d  = lock_hit ? 4'd0 : miss_inc;
            if (!lock_hit && miss_inc == 4'(LOSE_CNT)) begin
                state_d     = HUNT;
                match_cnt_d = '0;
                prev_d      = bus.in_data;
                lost_set    = 1'b1;
            end
        end
        lock_lost_d = lost_set | (lock_lost_q & !bus.err_clr);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
        end
    end
    prbs_sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.err_clr),
        .amt   (err_amt),
        .count (bus.err_count)
    );
    assign bus.locked    = state_q == LOCKED;
    assign bus.err_pulse = err_pulse_q;
    assign bus.lock_lost = lock_lost_q;
endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: directed table plus corner sequences for prbs8_checker and its saturating counter.
module tb_prbs8_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prbs8_checker_if bus();
    prbs8_checker dut (.clk(clk), .rst(rst), .bus(bus));

    logic        sc_clr;
    logic [3:0]  sc_amt;
    logic [15:0] sc_count;
    prbs_sat_counter sat (.clk(clk), .rst(rst), .clr(sc_clr), .amt(sc_amt), .count(sc_count));

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PRBS_CHK_BITERR_EN
    localparam logic [15:0] E1 = 16'd1, E2 = 16'd6, E3 = 16'd10, E4 = 16'd14, F1 = 16'd4, F2 = 16'd8;
`else
    localparam logic [15:0] E1 = 16'd1, E2 = 16'd2, E3 = 16'd3, E4 = 16'd4, F1 = 16'd1, F2 = 16'd2;
`endif

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        clr;
        logic        l;
        logic        p;
        logic [15:0] c;
        logic        lost;
    } vec_t;
    vec_t tbl[23];
    logic [7:0] s[32];

    function automatic logic [7:0] nxt(input logic [7:0] w);
        return {w[6:0], w[7] ^ w[5] ^ w[4] ^ w[3]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.err_clr  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input logic v, input logic [7:0] d, input logic clr,
                           input logic l, input logic p, input logic [15:0] c, input logic lost);
        tbl[i].v = v; tbl[i].d = d; tbl[i].clr = clr;
        tbl[i].l = l; tbl[i].p = p; tbl[i].c = c; tbl[i].lost = lost;
    endtask

    initial begin
        logic [7:0] cur;
        logic       pulse_seen;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.err_clr  = 1'b0;
        sc_clr = 1'b0;
        sc_amt = 4'd0;
        s[0] = 8'h01;
        for (int i = 1; i < 32; i++) s[i] = nxt(s[i-1]);
        set_row(0,  1, s[0],  0, 0, 0, 0,  0);
        set_row(1,  1, s[1],  0, 0, 0, 0,  0);
        set_row(2,  1, s[2],  0, 0, 0, 0,  0);
        set_row(3,  0, 8'hAA, 0, 0, 0, 0,  0);
        set_row(4,  1, s[3],  0, 0, 0, 0,  0);
        set_row(5,  1, s[4],  0, 1, 0, 0,  0);
        set_row(6,  1, s[5],  0, 1, 0, 0,  0);
        set_row(7,  1, 8'h46, 0, 1, 1, E1, 0);
        set_row(8,  1, s[7],  0, 1, 0, E1, 0);
        set_row(9,  1, s[8],  0, 1, 0, E1, 0);
        set_row(10, 1, 8'hFF, 0, 1, 1, E2, 0);
        set_row(11, 1, 8'hFF, 0, 1, 1, E3, 0);
        set_row(12, 1, 8'hFF, 0, 0, 1, E4, 1);
        set_row(13, 1, s[12], 0, 0, 0, E4, 1);
        set_row(14, 1, s[13], 0, 0, 0, E4, 1);
        set_row(15, 1, s[14], 0, 0, 0, E4, 1);
        set_row(16, 1, s[15], 0, 0, 0, E4, 1);
        set_row(17, 1, s[16], 0, 1, 0, E4, 1);
        set_row(18, 1, 8'h96, 1, 1, 1, 0,  0);
        set_row(19, 1, s[18], 0, 1, 0, 0,  0);
        set_row(20, 1, 8'hFF, 0, 1, 1, F1, 0);
        set_row(21, 1, 8'hFF, 0, 1, 1, F2, 0);
        set_row(22, 1, 8'hFF, 1, 0, 1, 0,  1);

        #1;
        chk("rst_locked", 16'(bus.locked), 0);
        chk("rst_pulse", 16'(bus.err_pulse), 0);
        chk("rst_count", bus.err_count, 0);
        chk("rst_lost", 16'(bus.lock_lost), 0);
        chk("rst_satcnt", sc_count, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].clr);
            chk($sformatf("row%0d_locked", i), 16'(bus.locked), 16'(tbl[i].l));
            chk($sformatf("row%0d_pulse", i), 16'(bus.err_pulse), 16'(tbl[i].p));
            chk($sformatf("row%0d_count", i), bus.err_count, tbl[i].c);
            chk($sformatf("row%0d_lost", i), 16'(bus.lock_lost), 16'(tbl[i].lost));
        end

        for (int i = 0; i < 50; i++) begin
            step(1'b1, 8'h00, 1'b0);
            chk("zero_locked", 16'(bus.locked), 0);
        end
        chk("zero_count", bus.err_count, 0);
        chk("zero_pulse", 16'(bus.err_pulse), 0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur = 8'h01;
        pulse_seen = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            step(1'b1, cur, 1'b0);
            cur = nxt(cur);
            if (i > 5) pulse_seen = pulse_seen | bus.err_pulse;
            if (i == 4) chk("clean_beat4_locked", 16'(bus.locked), 0);
            if (i == 5) chk("clean_beat5_locked", 16'(bus.locked), 1);
        end
        chk("clean_locked", 16'(bus.locked), 1);
        chk("clean_count", bus.err_count, 0);
        chk("clean_pulse_seen", 16'(pulse_seen), 0);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, ~cur, 1'b0);
            cur = nxt(cur);
        end
        chk("loss_locked", 16'(bus.locked), 0);
        chk("loss_lost", 16'(bus.lock_lost), 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, cur, 1'b0);
            cur = nxt(cur);
        end
        chk("relock_locked", 16'(bus.locked), 1);
        step(1'b1, ~cur, 1'b0);
        cur = nxt(cur);
        chk("prearst_pulse", 16'(bus.err_pulse), 1);
        chk("prearst_lost", 16'(bus.lock_lost), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_locked", 16'(bus.locked), 0);
        chk("arst_pulse", 16'(bus.err_pulse), 0);
        chk("arst_count", bus.err_count, 0);
        chk("arst_lost", 16'(bus.lock_lost), 0);
        @(negedge clk);
        rst = 1'b0;
        cur = 8'h01;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, cur, 1'b0);
            cur = nxt(cur);
            if (i == 4) chk("arst_relock4", 16'(bus.locked), 0);
            if (i == 5) chk("arst_relock5", 16'(bus.locked), 1);
        end

        @(negedge clk);
        bus.in_valid = 1'b0;
        sc_amt = 4'd8;
        for (int i = 0; i < 8191; i++) @(negedge clk);
        chk("sat_below", sc_count, 16'hFFF8);
        @(negedge clk);
        chk("sat_top", sc_count, 16'hFFFF);
        @(negedge clk);
        chk("sat_hold", sc_count, 16'hFFFF);
        sc_clr = 1'b1;
        @(negedge clk);
        chk("sat_clr_wins", sc_count, 16'h0000);
        sc_clr = 1'b0;
        sc_amt = 4'd3;
        @(negedge clk);
        chk("sat_add3", sc_count, 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end
endmodule
